// File: rtl/obi_apb_split_param_ss.sv
// OBI subordinate fanned out to NUM_TARGETS APB4 completers on a contiguous,
// equal-size address map, with per-target enables, decode errors and a wait timeout.
module obi_apb_split_param_ss #(
  parameter int                NUM_TARGETS = 4,
  parameter int                OBI_AW      = 32,
  parameter int                OBI_DW      = 32,
  parameter int                APB_AW      = 32,
  parameter int                APB_DW      = 32,
  parameter logic [OBI_AW-1:0] ADDR_BASE   = 32'h0103_0000,
  parameter int                SS_SIZE     = 32'h100,
  parameter int                TO_W        = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          obi_req_i,
  output logic                          obi_gnt_o,
  input  logic [OBI_AW-1:0]             obi_addr_i,
  input  logic                          obi_we_i,
  input  logic [OBI_DW/8-1:0]           obi_be_i,
  input  logic [OBI_DW-1:0]             obi_wdata_i,
  output logic                          obi_rvalid_o,
  input  logic                          obi_rready_i,
  output logic [OBI_DW-1:0]             obi_rdata_o,
  output logic                          obi_err_o,
  input  logic [NUM_TARGETS-1:0]        ss_ctrl_icn_i,
  input  logic [TO_W-1:0]               timeout_cfg_i,
  output logic [APB_AW-1:0]             apb_paddr_o,
  output logic [APB_DW-1:0]             apb_pwdata_o,
  output logic                          apb_pwrite_o,
  output logic [APB_DW/8-1:0]           apb_pstrb_o,
  output logic                          apb_penable_o,
  output logic [NUM_TARGETS-1:0]        apb_psel_o,
  input  logic [NUM_TARGETS*APB_DW-1:0] apb_prdata_i,
  input  logic [NUM_TARGETS-1:0]        apb_pready_i,
  input  logic [NUM_TARGETS-1:0]        apb_pslverr_i,
  output logic [1:0]                    state_o
);

  localparam int SLOT_W = (SS_SIZE > 1) ? $clog2(SS_SIZE) : 1;
  localparam int IDX_W  = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam logic [OBI_AW:0] MAP_LO = {1'b0, ADDR_BASE};
  localparam logic [OBI_AW:0] MAP_HI = MAP_LO + (OBI_AW+1)'(NUM_TARGETS * SS_SIZE);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_e;

  state_e state_q, state_d;

  logic [SLOT_W-1:0]   slot_q,  slot_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic                we_q,    we_d;
  logic [OBI_DW/8-1:0] be_q,    be_d;
  logic [OBI_DW-1:0]   wdata_q, wdata_d;
  logic [OBI_DW-1:0]   rdata_q, rdata_d;
  logic                err_q,   err_d;
  logic [TO_W-1:0]     cnt_q,   cnt_d;

  logic [OBI_AW-1:0] dec_offset;
  logic [IDX_W-1:0]  dec_idx;
  logic              dec_hit;
  logic              dec_en;
  logic              dec_valid;
  logic              grant;
  logic              apb_active;
  logic              timeout_hit;
  logic [APB_DW-1:0] sel_prdata;
  logic              sel_pready;
  logic              sel_pslverr;
  logic              unused_offset;

  // Address decode, evaluated against the live request so it is sampled at grant.
  assign dec_offset    = obi_addr_i - ADDR_BASE;
  assign dec_idx       = dec_offset[SLOT_W +: IDX_W];
  assign dec_hit       = ({1'b0, obi_addr_i} >= MAP_LO) && ({1'b0, obi_addr_i} < MAP_HI);
  assign unused_offset = ^dec_offset;

  always_comb begin
    dec_en = 1'b0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (dec_idx == IDX_W'(i)) dec_en = ss_ctrl_icn_i[i];
    end
  end

  assign dec_valid = dec_hit & dec_en;

  always_comb begin
    sel_prdata  = '0;
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_prdata  = apb_prdata_i[i*APB_DW +: APB_DW];
        sel_pready  = apb_pready_i[i];
        sel_pslverr = apb_pslverr_i[i];
      end
    end
  end

  // Handshakes: an OBI request is accepted on the edge where req & gnt are both
  // high; the response retires on the edge where rvalid & rready are both high.
  assign grant       = obi_gnt_o;
  assign timeout_hit = (timeout_cfg_i != '0) && (cnt_q == timeout_cfg_i - TO_W'(1));

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = dec_valid ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (sel_pready || timeout_hit) state_d = RESP;
      RESP:    if (obi_rready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    obi_gnt_o     = reset_n_i & obi_req_i & (state_q == IDLE);
    apb_active    = (state_q == SETUP) || (state_q == ACCESS);
    apb_penable_o = (state_q == ACCESS);
    obi_rvalid_o  = (state_q == RESP);
    obi_rdata_o   = obi_rvalid_o ? rdata_q : '0;
    obi_err_o     = obi_rvalid_o & err_q;
    apb_paddr_o   = apb_active ? APB_AW'(slot_q) : '0;
    apb_pwdata_o  = apb_active ? wdata_q : '0;
    apb_pwrite_o  = apb_active & we_q;
    apb_pstrb_o   = (apb_active && we_q) ? be_q : '0;
    apb_psel_o    = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      apb_psel_o[i] = apb_active && (idx_q == IDX_W'(i));
    end
    state_o       = state_q;
  end

  always_comb begin
    slot_d  = slot_q;
    idx_d   = idx_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          slot_d  = obi_addr_i[SLOT_W-1:0];
          idx_d   = dec_idx;
          we_d    = obi_we_i;
          be_d    = obi_be_i;
          wdata_d = obi_wdata_i;
          rdata_d = '0;
          err_d   = ~dec_valid;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + TO_W'(1);
        // A completion in the same cycle as the timeout takes priority.
        if (sel_pready) begin
          rdata_d = we_q ? '0 : sel_prdata;
          err_d   = sel_pslverr;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        if (obi_rready_i) cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      slot_q  <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_obi_apb_split_param_ss.sv
// Bench for obi_apb_split_param_ss: directed vector table, hand-written reset
// sequences and randomized transactions against a reference model.
module tb_obi_apb_split_param_ss;

  localparam int          N     = 4;
  localparam int          TO_W  = 8;
  localparam logic [31:0] BASE  = 32'h0103_0000;
  localparam int          SIZE  = 'h100;
  localparam int          NEVER = 255;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            obi_req, obi_gnt, obi_we, obi_rvalid, obi_rready, obi_err;
  logic [31:0]     obi_addr, obi_wdata, obi_rdata;
  logic [3:0]      obi_be;
  logic [N-1:0]    ss_ctrl;
  logic [TO_W-1:0] timeout_cfg;
  logic [31:0]     apb_paddr, apb_pwdata;
  logic            apb_pwrite, apb_penable;
  logic [3:0]      apb_pstrb;
  logic [N-1:0]    apb_psel, apb_pready, apb_pslverr;
  logic [N*32-1:0] apb_prdata;
  logic [1:0]      state;

  always #5 clk = ~clk;

  obi_apb_split_param_ss dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .obi_req_i(obi_req), .obi_gnt_o(obi_gnt), .obi_addr_i(obi_addr),
    .obi_we_i(obi_we), .obi_be_i(obi_be), .obi_wdata_i(obi_wdata),
    .obi_rvalid_o(obi_rvalid), .obi_rready_i(obi_rready),
    .obi_rdata_o(obi_rdata), .obi_err_o(obi_err),
    .ss_ctrl_icn_i(ss_ctrl), .timeout_cfg_i(timeout_cfg),
    .apb_paddr_o(apb_paddr), .apb_pwdata_o(apb_pwdata), .apb_pwrite_o(apb_pwrite),
    .apb_pstrb_o(apb_pstrb), .apb_penable_o(apb_penable), .apb_psel_o(apb_psel),
    .apb_prdata_i(apb_prdata), .apb_pready_i(apb_pready), .apb_pslverr_i(apb_pslverr),
    .state_o(state)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [N-1:0] ctrl;
    logic [N-1:0] ctrl_after;
    logic [7:0]  tcfg;
    int          wait_n;
    logic        slverr;
    logic [31:0] prd;
    int          hold;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [N-1:0] exp_psel;
    logic [31:0] exp_paddr;
    logic [3:0]  exp_pstrb;
    int          exp_pen;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  vec_t table_v[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic we, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [N-1:0] ctrl,
                              input logic [N-1:0] ctrl_after, input logic [7:0] tcfg,
                              input int wait_n, input logic slverr, input logic [31:0] prd,
                              input int hold, input int exp_cyc, input logic exp_err,
                              input logic [31:0] exp_rdata, input logic [N-1:0] exp_psel,
                              input logic [31:0] exp_paddr, input logic [3:0] exp_pstrb,
                              input int exp_pen);
    vec_t v;
    v.addr = addr; v.we = we; v.be = be; v.wdata = wdata; v.ctrl = ctrl;
    v.ctrl_after = ctrl_after; v.tcfg = tcfg; v.wait_n = wait_n; v.slverr = slverr;
    v.prd = prd; v.hold = hold; v.exp_cyc = exp_cyc; v.exp_err = exp_err;
    v.exp_rdata = exp_rdata; v.exp_psel = exp_psel; v.exp_paddr = exp_paddr;
    v.exp_pstrb = exp_pstrb; v.exp_pen = exp_pen;
    return v;
  endfunction

  // Reference model: byte-offset arithmetic on the address map, then response
  // shape from wait count versus timeout budget.
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    longint off;
    int     idx;
    bit     mapped;
    r      = v;
    off    = longint'(v.addr) - longint'(BASE);
    mapped = (off >= 0) && (off < N * SIZE);
    idx    = mapped ? int'(off / SIZE) : 0;
    if (mapped) mapped = v.ctrl[idx];
    if (!mapped) begin
      r.exp_cyc = 1; r.exp_err = 1'b1; r.exp_rdata = '0; r.exp_psel = '0;
      r.exp_paddr = '0; r.exp_pstrb = '0; r.exp_pen = 0;
    end else begin
      r.exp_psel  = '0;
      r.exp_psel[idx] = 1'b1;
      r.exp_paddr = 32'(off % SIZE);
      r.exp_pstrb = v.we ? v.be : 4'h0;
      if (v.tcfg != 0 && v.wait_n >= int'(v.tcfg)) begin
        r.exp_pen = int'(v.tcfg); r.exp_err = 1'b1; r.exp_rdata = '0;
      end else begin
        r.exp_pen = v.wait_n + 1; r.exp_err = v.slverr; r.exp_rdata = v.we ? 32'h0 : v.prd;
      end
      r.exp_cyc = r.exp_pen + 2;
    end
    return r;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    int          tgt, acc, resp_cyc, proto_bad, fld_bad, rsp_bad, hold_left;
    bit          done;
    logic        exp_pen_k;
    logic [N-1:0] exp_sel_k;
    logic [31:0] first_rdata, exp_rd;
    logic        first_err;
    longint      off;
    off = longint'(v.addr) - longint'(BASE);
    tgt = (off >= 0 && off < N * SIZE) ? int'(off / SIZE) : 0;
    for (int t = 0; t < N; t++) apb_prdata[t*32 +: 32] = (t == tgt) ? v.prd : $urandom;
    exp_q.push_back(v.exp_rdata);
    apb_pready  = '0;
    apb_pslverr = '0;
    ss_ctrl     = v.ctrl;
    timeout_cfg = v.tcfg;
    obi_addr = v.addr; obi_we = v.we; obi_be = v.be; obi_wdata = v.wdata;
    obi_req = 1'b1; obi_rready = 1'b0;
    @(negedge clk);
    chk({tag, " gnt"}, obi_gnt, 1);
    acc = 0; resp_cyc = -1; proto_bad = 0; fld_bad = 0; rsp_bad = 0;
    hold_left = v.hold; done = 0; first_rdata = '0; first_err = 1'b0;
    for (int k = 1; k <= 600 && !done; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        obi_req = 1'b0;
        ss_ctrl = v.ctrl_after;
      end
      for (int t = 0; t < N; t++) begin
        apb_pready[t]  = apb_psel[t] ? (apb_penable && acc >= v.wait_n) : 1'($urandom_range(0, 1));
        apb_pslverr[t] = apb_psel[t] ? v.slverr : 1'($urandom_range(0, 1));
      end
      if (obi_rvalid) begin
        if (hold_left > 0) begin
          obi_rready = 1'b0; obi_req = 1'b1; hold_left--;
        end else begin
          obi_rready = 1'b1; obi_req = 1'b0;
        end
      end
      @(negedge clk);
      exp_sel_k = (k <= 1 + v.exp_pen) ? v.exp_psel : '0;
      exp_pen_k = (v.exp_psel != '0) && (k >= 2) && (k <= 1 + v.exp_pen);
      if (apb_psel !== exp_sel_k) proto_bad++;
      if (apb_penable !== exp_pen_k) proto_bad++;
      if (apb_penable) acc++;
      if (apb_psel != '0) begin
        if (apb_paddr !== v.exp_paddr || apb_pstrb !== v.exp_pstrb ||
            apb_pwrite !== v.we || apb_pwdata !== v.wdata) fld_bad++;
      end
      if (obi_rvalid) begin
        if (resp_cyc < 0) begin
          resp_cyc = k; first_rdata = obi_rdata; first_err = obi_err;
        end
        if (obi_rdata !== v.exp_rdata || obi_err !== v.exp_err) rsp_bad++;
        if (obi_req && obi_gnt) rsp_bad++;
        if (obi_rready) done = 1;
      end
    end
    chk({tag, " completed"}, done, 1);
    exp_rd = exp_q.pop_front();
    chk({tag, " resp_cycle"}, resp_cyc, v.exp_cyc);
    chk({tag, " rdata"}, first_rdata, exp_rd);
    chk({tag, " err"}, first_err, v.exp_err);
    chk({tag, " penable_cycles"}, acc, v.exp_pen);
    chk({tag, " psel_penable_bad"}, proto_bad, 0);
    chk({tag, " apb_fields_bad"}, fld_bad, 0);
    chk({tag, " resp_hold_bad"}, rsp_bad, 0);
    @(posedge clk); #1;
    obi_rready = 1'b0;
    obi_req    = 1'b0;
  endtask

  initial begin
    vec_t v;
    reset_n = 1'b0; obi_req = 1'b1; obi_addr = BASE; obi_we = 1'b0; obi_be = '0;
    obi_wdata = '0; obi_rready = 1'b0; ss_ctrl = '1; timeout_cfg = '0;
    apb_prdata = '0; apb_pready = '0; apb_pslverr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset gnt", obi_gnt, 0);
    chk("reset rvalid", obi_rvalid, 0);
    chk("reset psel", apb_psel, 0);
    chk("reset penable", apb_penable, 0);
    chk("reset rdata_err", {obi_rdata, obi_err}, 0);
    chk("reset apb_bus", {apb_paddr, apb_pwdata, apb_pstrb, apb_pwrite}, 0);
    obi_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // addr we be wdata ctrl ctrl_after tcfg wait slverr prd hold | cyc err rdata psel paddr pstrb pen
    table_v.push_back(mk(32'h0103_0204, 0, 4'h0, 32'h0,         4'hF, 4'hF, 0, 0,     0, 32'hDEAD_BEEF, 0, 3, 0, 32'hDEAD_BEEF, 4'b0100, 32'h04, 4'h0, 1));
    table_v.push_back(mk(32'h0103_0310, 1, 4'h3, 32'hA5A5_1234, 4'hF, 4'hF, 0, 3,     0, 32'h1111_2222, 0, 6, 0, 32'h0,         4'b1000, 32'h10, 4'h3, 4));
    table_v.push_back(mk(32'h0103_0400, 0, 4'h0, 32'h0,         4'hF, 4'hF, 0, 0,     0, 32'h5555_5555, 0, 1, 1, 32'h0,         4'b0000, 32'h00, 4'h0, 0));
    table_v.push_back(mk(32'h0103_0100, 0, 4'h0, 32'h0,         4'hD, 4'hD, 0, 0,     0, 32'h7777_7777, 0, 1, 1, 32'h0,         4'b0000, 32'h00, 4'h0, 0));
    table_v.push_back(mk(32'h0103_0008, 0, 4'h0, 32'h0,         4'hD, 4'hD, 0, 0,     1, 32'h1234_5678, 0, 3, 1, 32'h1234_5678, 4'b0001, 32'h08, 4'h0, 1));
    table_v.push_back(mk(32'h0103_0000, 0, 4'h0, 32'h0,         4'hF, 4'hF, 5, NEVER, 0, 32'h9999_0000, 0, 7, 1, 32'h0,         4'b0001, 32'h00, 4'h0, 5));
    table_v.push_back(mk(32'h0103_0000, 0, 4'h0, 32'h0,         4'hF, 4'hF, 5, 4,     0, 32'h9999_0001, 0, 7, 0, 32'h9999_0001, 4'b0001, 32'h00, 4'h0, 5));
    table_v.push_back(mk(32'h0103_01FC, 0, 4'h0, 32'h0,         4'hF, 4'hF, 0, 0,     0, 32'hCAFE_F00D, 4, 3, 0, 32'hCAFE_F00D, 4'b0010, 32'hFC, 4'h0, 1));
    table_v.push_back(mk(32'h0102_FFFC, 0, 4'h0, 32'h0,         4'hF, 4'hF, 0, 0,     0, 32'h4444_4444, 0, 1, 1, 32'h0,         4'b0000, 32'h00, 4'h0, 0));
    table_v.push_back(mk(32'h0103_0304, 0, 4'h0, 32'h0,         4'hF, 4'h0, 0, 0,     0, 32'h0BAD_CAFE, 0, 3, 0, 32'h0BAD_CAFE, 4'b1000, 32'h04, 4'h0, 1));
    table_v.push_back(mk(32'h0103_00F0, 1, 4'hF, 32'h0123_4567, 4'hF, 4'hF, 0, 0,     1, 32'h3333_3333, 0, 3, 1, 32'h0,         4'b0001, 32'hF0, 4'hF, 1));
    table_v.push_back(mk(32'h0103_03FF, 0, 4'h0, 32'h0,         4'hF, 4'hF, 1, 2,     0, 32'h2222_2222, 2, 3, 1, 32'h0,         4'b1000, 32'hFF, 4'h0, 1));

    for (int i = 0; i < table_v.size(); i++) apply(table_v[i], $sformatf("vec%0d", i));

    // Reset while the completer is stalling in ACCESS: nothing may be returned.
    obi_addr = 32'h0103_0100; obi_we = 1'b0; ss_ctrl = '1; timeout_cfg = '0;
    apb_pready = '0; obi_req = 1'b1;
    @(negedge clk);
    chk("rst_mid gnt", obi_gnt, 1);
    @(posedge clk); #1; obi_req = 1'b0;
    @(posedge clk); #1; reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid penable_before", apb_penable, 1);
    @(posedge clk); #1; reset_n = 1'b1; apb_pready = '1;
    @(negedge clk);
    chk("rst_mid psel", apb_psel, 0);
    chk("rst_mid penable", apb_penable, 0);
    chk("rst_mid rvalid", obi_rvalid, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1; apb_pready = $urandom;
      @(negedge clk);
      chk($sformatf("rst_mid quiet%0d", k), {obi_rvalid, apb_psel, apb_penable}, 0);
    end
    @(posedge clk); #1; apb_pready = '0;

    for (int i = 0; i < 60; i++) begin
      v.addr       = BASE - 32'h80 + 32'($urandom_range(0, N * SIZE + 'h100));
      v.we         = 1'($urandom_range(0, 1));
      v.be         = 4'($urandom);
      v.wdata      = $urandom;
      v.ctrl       = N'($urandom);
      v.ctrl_after = N'($urandom);
      v.tcfg       = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      v.wait_n     = (v.tcfg != 0 && $urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, 7));
      v.slverr     = 1'($urandom_range(0, 1));
      v.prd        = $urandom;
      v.hold       = int'($urandom_range(0, 3));
      apply(model(v), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obi_apb_split_param_ss.md
Name: obi_apb_split_param_ss

Overview:
Parametrised OBI-to-multi-APB bridge: one OBI subordinate port fans out to NUM_TARGETS APB4 completers laid out on a contiguous, equal-size address map.
- Successor of the fixed 4-way peripheral split; sits between the system OBI crossbar and subsystem APB register blocks.
- Adds per-target enable gating from ss_ctrl, an error response for unmapped or disabled addresses, and a programmable APB wait-state timeout.
- One outstanding transaction; no external xbar or converter instances.

Parameters:
- NUM_TARGETS, 4, number of APB completers (1..16)
- OBI_AW, 32, OBI address width
- OBI_DW, 32, OBI data width (equals APB_DW)
- APB_AW, 32, APB address width
- APB_DW, 32, APB data width
- ADDR_BASE, 32'h0103_0000, base of target 0
- SS_SIZE, 32'h100, bytes per target; power of two
- TO_W, 8, timeout counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- obi_req  in  1  OBI A-channel request
- obi_gnt  out  1  OBI grant
- obi_addr  in  OBI_AW  byte address
- obi_we  in  1  write enable
- obi_be  in  OBI_DW/8  byte enables
- obi_wdata  in  OBI_DW  write data
- obi_rvalid  out  1  R-channel valid
- obi_rready  in  1  R-channel ready
- obi_rdata  out  OBI_DW  read data
- obi_err  out  1  response error
- ss_ctrl_icn  in  NUM_TARGETS  per-target enable, bit i gates target i
- timeout_cfg  in  TO_W  max ACCESS cycles; 0 disables timeout
- apb_paddr  out  APB_AW  shared address (slot offset)
- apb_pwdata  out  APB_DW  shared write data
- apb_pwrite  out  1  shared write flag
- apb_pstrb  out  APB_DW/8  shared strobes
- apb_penable  out  1  shared enable
- apb_psel  out  NUM_TARGETS  one-hot select
- apb_prdata  in  NUM_TARGETS*APB_DW  packed read data, target i at [i*APB_DW +: APB_DW]
- apb_pready  in  NUM_TARGETS  per-target ready
- apb_pslverr  in  NUM_TARGETS  per-target error

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is synchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- Reset asserted mid-transaction: abort at the next edge, drop psel/penable and any pending rvalid, no response issued.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- obi_gnt = obi_req & (state==IDLE), combinational.
- On grant: register addr, we, be, wdata.
- Decode:
  - hit = addr >= ADDR_BASE and addr < ADDR_BASE + NUM_TARGETS*SS_SIZE
  - idx = (addr - ADDR_BASE) >> log2(SS_SIZE)
  - valid = hit & ss_ctrl_icn[idx], sampled at grant
- IDLE transitions: IDLE -> SETUP if valid; IDLE -> RESP with err=1, rdata=0 otherwise.
- SETUP (1 cycle): psel[idx]=1, penable=0; paddr = zero-extended addr[log2(SS_SIZE)-1:0]; pwrite=we; pwdata=wdata; pstrb = we ? be : 0.
- ACCESS: psel[idx]=1, penable=1; APB signals held stable; counter increments each cycle.
  - pready[idx]=1 -> RESP; rdata = we ? 0 : prdata slice idx; err = pslverr[idx].
  - Timeout: timeout_cfg != 0, counter == timeout_cfg-1 and no pready -> RESP with err=1, rdata=0; psel/penable deassert.
  - pready arriving in the same cycle as the timeout wins; no timeout error.
- RESP: rvalid=1; rdata/err held until rready. On rvalid&rready -> IDLE; counter cleared.
- A new grant is possible only in IDLE, so the next request is granted the cycle after rready.
- Latency, zero-wait APB: grant cycle 0, SETUP 1, ACCESS 2, rvalid 3. Unmapped or disabled: rvalid in cycle 1.
- ss_ctrl_icn changes after grant do not affect the in-flight transaction.
- psel is never multi-hot; all psel=0 outside SETUP/ACCESS.

Test Plan:
- Read 0x0103_0204, all enabled, target 2 pready=1 first ACCESS cycle, prdata=0xDEADBEEF -> psel=4'b0100, paddr=0x04, rvalid in cycle 3, rdata=0xDEADBEEF, err=0.
- Write 0x0103_0310, be=4'b0011, wdata=0xA5A5_1234, target 3 holds pready low for 3 cycles -> pstrb=0011, pwrite=1, APB signals stable over 4 ACCESS cycles, rvalid cycle 6, rdata=0, err=0.
- Read 0x0103_0400 (NUM_TARGETS=4) -> no psel, rvalid cycle 1, err=1, rdata=0.
- ss_ctrl_icn=4'b1101, read 0x0103_0100 -> target 1 never selected, err=1. Repeat with a target-0 pslverr=1 read -> err=1.
- timeout_cfg=5, target 0 never ready -> penable high exactly 5 cycles, then rvalid with err=1. Repeat with pready on the 5th cycle -> err=0.
- rready held low 4 cycles in RESP with obi_req high -> rvalid/rdata stable, gnt=0. Separately, reset_n=0 during ACCESS -> next cycle psel=0, penable=0, rvalid=0, FSM in IDLE.
